// File: rtl/one_to3_demux_buf_pkg.sv
// Shared types for the 1-to-3 demultiplexing buffer: select encodings,
// per-destination buffer states and the saturating drop-counter helper.
package one_to3_demux_buf_pkg;

   typedef enum logic [1:0] {
      SEL_OUT0 = 2'd0,
      SEL_OUT1 = 2'd1,
      SEL_OUT2 = 2'd2,
      SEL_DROP = 2'd3
   } sel_e;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   localparam int          NUM_DEST  = 3;
   localparam logic [7:0]  DROP_MAX  = 8'd255;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == DROP_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/one_to3_demux_buf_buffer.sv
// One-entry register buffer (EMPTY/FULL); a write and a drain on the same
// edge keeps it FULL with the new word, so a stream sustains one word per cycle.
module one_entry_buffer
   import one_to3_demux_buf_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         wr_en,
   input  logic [N-1:0] wr_data,
   input  logic         rd_ready,
   output logic         full,
   output logic [N-1:0] data
);

   buf_state_e state, state_nxt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= BUF_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: next-state default is assigned first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         BUF_EMPTY: if (wr_en)              state_nxt = BUF_FULL;
         BUF_FULL:  if (rd_ready && !wr_en) state_nxt = BUF_EMPTY;
         default:                           state_nxt = BUF_EMPTY;
      endcase
   end

   // NOTE: the data register is reset too, because outK_data must read 0
   // while reset is held and no stale word may survive a reset.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         data <= '0;
      end else if (wr_en) begin
         data <= wr_data;
      end
   end

   assign full = (state == BUF_FULL);

endmodule

// File: rtl/one_to3_demux_buf.sv
// Routes each accepted word to one of three one-entry buffers by in_select;
// select 3 discards the word and bumps a saturating drop counter.
module one_to3_demux_buf
   import one_to3_demux_buf_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   in_select,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] out0_data,
   output logic [N-1:0] out1_data,
   output logic [N-1:0] out2_data,
   output logic         out0_valid,
   output logic         out1_valid,
   output logic         out2_valid,
   input  logic         out0_ready,
   input  logic         out1_ready,
   input  logic         out2_ready,
   output logic [7:0]   drop_count
);

   logic [NUM_DEST-1:0] full;
   logic [NUM_DEST-1:0] rd_ready;
   logic [NUM_DEST-1:0] wr_en;
   logic                drop_en;
   logic [N-1:0]        buf_data [NUM_DEST];

   assign rd_ready = {out2_ready, out1_ready, out0_ready};

   // A full buffer can take a new word in the same cycle it is drained.
   always_comb begin
      in_ready = 1'b1;
      wr_en    = '0;
      drop_en  = 1'b0;
      unique case (sel_e'(in_select))
         SEL_OUT0: begin
            in_ready = !full[0] || rd_ready[0];
            wr_en[0] = in_valid && in_ready;
         end
         SEL_OUT1: begin
            in_ready = !full[1] || rd_ready[1];
            wr_en[1] = in_valid && in_ready;
         end
         SEL_OUT2: begin
            in_ready = !full[2] || rd_ready[2];
            wr_en[2] = in_valid && in_ready;
         end
         SEL_DROP: begin
            in_ready = 1'b1;
            drop_en  = in_valid;
         end
         default: ;
      endcase
   end

   for (genvar k = 0; k < NUM_DEST; k++) begin : g_buf
      one_entry_buffer #(.N(N)) u_buf (
         .clk      (clk),
         .rstb     (rstb),
         .wr_en    (wr_en[k]),
         .wr_data  (in_data),
         .rd_ready (rd_ready[k]),
         .full     (full[k]),
         .data     (buf_data[k])
      );
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         drop_count <= '0;
      end else if (drop_en) begin
         drop_count <= sat_inc(drop_count);
      end
   end

   assign out0_data  = buf_data[0];
   assign out1_data  = buf_data[1];
   assign out2_data  = buf_data[2];
   assign out0_valid = full[0];
   assign out1_valid = full[1];
   assign out2_valid = full[2];

endmodule
